// File: rtl/fetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, keeps one request outstanding to a
// variable-latency imem, and feeds IF/ID with a one-entry skid buffer for decode stalls.
// Optional fetch counter port and logic are enabled by defining FETCH_PERFCNT_EN.
module fetch_stage #(
  parameter int           N        = 64,
  parameter logic [N-1:0] PC_RESET = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         PCSrc,
  input  logic [N-1:0] PCBranch,
  input  logic         stall,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic         imem_ready,
  input  logic [31:0]  imem_rdata,
  output logic [31:0]  instr_D,
  output logic [N-1:0] pc_D,
  output logic         valid_D,
  output logic [10:0]  Op_D
`ifdef FETCH_PERFCNT_EN
  ,
  output logic [31:0]  fetch_count
`endif
);

  typedef enum logic [1:0] {RUN, HOLD, DROP} state_t;

  state_t         state_reg, state_next;
  logic [N-1:0]   pc_reg, pc_next;
  logic [31:0]    instr_reg, instr_next;
  logic [N-1:0]   pcd_reg, pcd_next;
  logic           valid_reg, valid_next;
  logic [31:0]    skid_instr_reg, skid_instr_next;
  logic [N-1:0]   skid_pc_reg, skid_pc_next;
  logic [N-1:0]   stale_reg, stale_next;
  logic           load_valid;

  logic [N-1:0]   target;
  logic [N-1:0]   pc_inc;

  // Masking keeps every PCBranch bit in the expression while forcing word alignment.
  assign target = PCBranch & ~N'(3);
  assign pc_inc = pc_reg + N'(4);

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    instr_next      = instr_reg;
    pcd_next        = pcd_reg;
    valid_next      = valid_reg;
    skid_instr_next = skid_instr_reg;
    skid_pc_next    = skid_pc_reg;
    stale_next      = stale_reg;
    load_valid      = 1'b0;
    imem_req        = 1'b0;
    imem_addr       = pc_reg;

    case (state_reg)
      RUN: begin
        imem_req = 1'b1;
        if (PCSrc) begin
          valid_next = 1'b0;
          pc_next    = target;
          // An unanswered request must still be drained at its original address.
          if (!imem_ready) begin
            stale_next = pc_reg;
            state_next = DROP;
          end
        end else if (imem_ready) begin
          pc_next = pc_inc;
          if (!stall || !valid_reg) begin
            instr_next = imem_rdata;
            pcd_next   = pc_reg;
            valid_next = 1'b1;
            load_valid = 1'b1;
          end else begin
            skid_instr_next = imem_rdata;
            skid_pc_next    = pc_reg;
            state_next      = HOLD;
          end
        end else if (!stall) begin
          valid_next = 1'b0;
        end
      end

      HOLD: begin
        if (PCSrc) begin
          valid_next = 1'b0;
          pc_next    = target;
          state_next = RUN;
        end else if (!stall) begin
          instr_next = skid_instr_reg;
          pcd_next   = skid_pc_reg;
          valid_next = 1'b1;
          load_valid = 1'b1;
          state_next = RUN;
        end
      end

      DROP: begin
        imem_req  = 1'b1;
        imem_addr = stale_reg;
        if (PCSrc) begin
          valid_next = 1'b0;
          pc_next    = target;
        end
        if (imem_ready) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next = RUN;
      end
    endcase

    if (reset) begin
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RUN;
      pc_reg         <= PC_RESET;
      instr_reg      <= '0;
      pcd_reg        <= '0;
      valid_reg      <= 1'b0;
      skid_instr_reg <= '0;
      skid_pc_reg    <= '0;
      stale_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      instr_reg      <= instr_next;
      pcd_reg        <= pcd_next;
      valid_reg      <= valid_next;
      skid_instr_reg <= skid_instr_next;
      skid_pc_reg    <= skid_pc_next;
      stale_reg      <= stale_next;
    end
  end

  assign instr_D = instr_reg;
  assign pc_D    = pcd_reg;
  assign valid_D = valid_reg;
  assign Op_D    = instr_reg[31:21];

`ifdef FETCH_PERFCNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load_valid) begin
      count_reg <= count_reg + 32'd1;
    end
  end

  assign fetch_count = count_reg;
`endif

endmodule
